// File: rtl/pwm.sv
// Counter-based pulse-width modulator: drives out high for `in` cycles of every
// `period`-cycle frame, with the duty value reloaded only at frame wrap.
module pwm #(
  parameter int unsigned period = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [$clog2(period+1)-1:0]   in,
  output logic                          out
);

  localparam int unsigned W  = $clog2(period + 1);
  localparam int unsigned CW = (period > 1) ? $clog2(period) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(period - 1);
  localparam logic [W-1:0]  DUTY_MAX = W'(period);

  if (period < 1) begin : g_bad_period
    $error("pwm: period must be >= 1");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  duty_q, duty_d;
  logic          out_q, out_d;
  logic          cnt_wrap;

  // Next-state: free-running frame counter, duty sampled (saturated) at the wrap edge.
  always_comb begin
    cnt_wrap = (cnt_q == CNT_LAST);
    cnt_d    = cnt_wrap ? '0 : cnt_q + CW'(1);
    duty_d   = duty_q;
    if (cnt_wrap) begin
      duty_d = (in > DUTY_MAX) ? DUTY_MAX : in;
    end
    out_d    = (W'(cnt_q) < duty_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      duty_q <= '0;
      out_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_pwm.sv
// Scoreboard bench for pwm at period 7, 10 and 1: a frame-level model queues the
// expected output bits per instance and a negedge monitor compares them.
module tb_pwm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a, rst_n_b, rst_n_c;
  logic [2:0] in_a;
  logic [3:0] in_b;
  logic [0:0] in_c;
  logic       out_a, out_b, out_c;

  pwm #(.period(7))  dut_a (.clk(clk), .rst_n(rst_n_a), .in(in_a), .out(out_a));
  pwm #(.period(10)) dut_b (.clk(clk), .rst_n(rst_n_b), .in(in_b), .out(out_b));
  pwm #(.period(1))  dut_c (.clk(clk), .rst_n(rst_n_c), .in(in_c), .out(out_c));

  int checks = 0;
  int errors = 0;

  bit exp_q [3][$];
  bit started [3] = '{0, 0, 0};
  int edge_cnt [3] = '{0, 0, 0};

  function automatic int period_of(int i);
    case (i)
      0:       return 7;
      1:       return 10;
      default: return 1;
    endcase
  endfunction

  function automatic bit rst_of(int i);
    case (i)
      0:       return rst_n_a;
      1:       return rst_n_b;
      default: return rst_n_c;
    endcase
  endfunction

  function automatic int in_of(int i);
    case (i)
      0:       return int'(in_a);
      1:       return int'(in_b);
      default: return int'(in_c);
    endcase
  endfunction

  function automatic logic out_of(int i);
    case (i)
      0:       return out_a;
      1:       return out_b;
      default: return out_c;
    endcase
  endfunction

  // Reference model: each frame is P cycles, min(duty,P) high first; duty is the
  // input seen at the frame's opening edge, the first frame after reset is all low.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int p;
      p = period_of(i);
      if (!rst_of(i)) begin
        started[i]  = 1'b1;
        edge_cnt[i] = 0;
        exp_q[i].delete();
        exp_q[i].push_back(1'b0);
        for (int k = 0; k < p; k++) exp_q[i].push_back(1'b0);
      end else if (started[i]) begin
        edge_cnt[i]++;
        if (edge_cnt[i] % p == 0) begin
          int d;
          d = (in_of(i) > p) ? p : in_of(i);
          for (int k = 0; k < p; k++) exp_q[i].push_back(k < d);
        end
      end
    end
  end

  // Monitor: one output sample per clock per instance once it has seen reset.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (started[i]) begin
        checks++;
        if (exp_q[i].size() == 0) begin
          errors++;
          $display("FAIL underflow dut%0d: no expected value queued at %0t", i, $time);
        end else begin
          bit e;
          logic o;
          e = exp_q[i].pop_front();
          o = out_of(i);
          if (o !== e) begin
            errors++;
            $display("FAIL out dut%0d (period %0d) at %0t: got %b expected %b",
                     i, period_of(i), $time, o, e);
          end
        end
      end
    end
  end

  // Period 10 and period 1 stimulus: saturation, random duty, random resets.
  initial begin
    rst_n_b = 1'b0;
    rst_n_c = 1'b0;
    in_b    = '0;
    in_c    = '0;
    repeat (3) @(negedge clk);
    rst_n_b = 1'b1;
    rst_n_c = 1'b1;
    in_b    = 4'd15;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      in_c = 1'($urandom);
      if (cyc == 100) in_b = 4'd3;
      if (cyc > 150 && $urandom_range(0, 7) == 0) in_b = 4'($urandom);
      rst_n_b = !(cyc > 200 && $urandom_range(0, 59) == 0);
      rst_n_c = !(cyc > 200 && $urandom_range(0, 59) == 0);
      @(negedge clk);
    end
  end

  // Period 7 stimulus: directed phases then randomized duty and resets.
  initial begin
    bit hit;
    rst_n_a = 1'b0;
    in_a    = '0;
    repeat (3) @(negedge clk);
    rst_n_a = 1'b1;
    in_a    = 3'd3;
    repeat (72) @(negedge clk);
    in_a = 3'd6;
    repeat (30) @(negedge clk);
    in_a = 3'd0;
    repeat (30) @(negedge clk);
    in_a = 3'd7;
    repeat (30) @(negedge clk);

    // Reset while the output is high.
    in_a = 3'd5;
    repeat (20) @(negedge clk);
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk);
      if (out_a === 1'b1) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_high dut0: out never high within 20 cycles, got %b expected 1", out_a);
    end
    rst_n_a = 1'b0;
    @(negedge clk);
    rst_n_a = 1'b1;
    repeat (30) @(negedge clk);

    for (int cyc = 0; cyc < 300; cyc++) begin
      if ($urandom_range(0, 5) == 0) in_a = 3'($urandom);
      rst_n_a = !($urandom_range(0, 79) == 0);
      @(negedge clk);
    end
    rst_n_a = 1'b1;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm.md
Name: pwm

Overview:
- Counter-based pulse-width modulator with a compile-time period and a run-time duty value.
- Drives one output high for `in` clock cycles out of every `period` cycles.
- Duty changes take effect only on period boundaries, so output pulses are glitch-free.
- Used as a leaf block for LED dimming, simple DAC and motor drive; one clock domain.

Parameters:
- period, default 7: PWM frame length in clock cycles. Must be >= 1; elaboration fails otherwise.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in  input  $clog2(period+1)  requested duty, meaning high cycles per frame. 3 bits at period=7.
- out  input/output: output  1  registered PWM output.

Behaviour:
- One clock; reset is synchronous and active-low. Reset is sampled only on the rising edge of clk, and rst_n=0 wins over all other activity.
- Width rules:
  - W = $clog2(period+1) for in and for the internal duty register.
  - Counter width is max(1, $clog2(period)).
- Internal state:
  - cnt: frame counter, 0..period-1.
  - duty: latched duty.
  - out: registered output.
- Reset (edge with rst_n=0): cnt=0, duty=0, out=0. A mid-frame reset aborts the frame immediately; the first frame after reset is always all-low.
- Counter, on every edge with rst_n=1: cnt <= (cnt==period-1) ? 0 : cnt+1.
- Duty latch:
  - On the edge where cnt==period-1, duty <= sat(in). sat(x) = (x > period) ? period : x.
  - in is ignored at all other times; mid-frame changes are deferred to the next frame.
- Output, on every edge with rst_n=1: out <= (cnt < duty).
  - Output latency: one clock after the counter/duty state it reflects.
- Resulting frame shape: each frame is exactly period cycles, with min(duty,period) high cycles first, then the remaining cycles low.
- Boundary values:
  - duty=0: out constantly 0.
  - duty=period: out constantly 1, with no low glitch at frame wrap.
  - in > period (possible when period+1 is not a power of two): saturates to always-high.
- period=1:
  - cnt stays 0 and duty reloads every edge.
  - out follows in[0] with two cycles latency.
- in is synchronous to clk. No internal synchronizer; asynchronous sources must be synchronized upstream.
- No X propagation on out after the first reset edge.

Test Plan:
- Reset then in=3, period=7, run 10 frames:
  - First 8 cycles after reset release out=0.
  - Afterwards a repeating pattern of 3 high, 4 low (1110000).
  - Exactly 3 high cycles in every 7-cycle window aligned to the frame start.
- in=3 steady, change to 6 mid-frame (at cnt=2):
  - The current frame completes as 3 high/4 low.
  - The next frame onward is 6 high/1 low (1111110); no frame has a truncated or extended pulse.
- in=0 then in=7 with period=7:
  - out constantly 0 for all frames with duty 0.
  - After the update, out constantly 1 with no low cycle at any wrap.
- period=10, in=15 (W=4): out saturates to constantly 1; 10 high of 10.
- Reset asserted mid-frame while out=1 (in=5):
  - out=0 on the next edge.
  - out stays 0 through the whole following frame.
  - The 5/2 pattern resumes on the second frame after release.
- period=1, toggle in:
  - out tracks in with a 2-cycle delay.
  - cnt never leaves 0.
